// File: rtl/apb_adc_sampler.sv
// apb_adc_sampler
//   APB slave that samples ADC_DATA at a programmable rate into a circular
//   FIFO. Firmware drains bursts of samples through the DATA register.
//   The FIFO also tracks overflow and raises a watermark interrupt.
//
//   Optional feature macro: ADC_CMP_EN
//     When defined, a CMP register at 0x10 is implemented. Any pushed sample
//     strictly above CMP sets the sticky CMPHIT flag (STATUS[19]), and
//     CMPHIT feeds IRQ. When undefined, 0x10 reads 0 and CMPHIT is 0.
//
//   Parameters: DATA_WIDTH (1..32), FIFO_DEPTH (power of two, 2..256),
//               DIV_WIDTH (sample-rate divider width, up to 32)
//   Ports:
//     PCLK, PRESETn                 clock, async active-low reset
//     PSEL/PENABLE/PWRITE/PADDR     APB control; only PADDR[4:2] decoded
//     PWDATA, PRDATA                APB write / combinational read data
//     PREADY, PSLVERR               tied 1 / 0
//     ADC_DATA                      ADC code, stable in the PCLK domain
//     IRQ                           registered level interrupt
module apb_adc_sampler #(
   parameter int DATA_WIDTH = 12,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [11:0]           PADDR,
   input  logic [31:0]           PWDATA,
   output logic [31:0]           PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   input  logic [DATA_WIDTH-1:0] ADC_DATA,
   output logic                  IRQ
);
   localparam int         AW    = $clog2(FIFO_DEPTH);
   localparam logic [8:0] DEPTH = 9'(FIFO_DEPTH);

   logic                  en_reg, ie_reg;
   logic [7:0]            wm_reg;
   logic [DIV_WIDTH-1:0]  div_reg, cnt_reg;
   logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [8:0]            count_reg;
   logic                  ovr_reg, irq_reg;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [2:0]  reg_sel;
   logic        wr_acc, rd_acc;
   logic        ctrl_wr, div_wr, status_wr;
   logic        clr, empty, full, strobe, pop, push, ovr_set;
   logic        cmphit;
   logic [31:0] cmp_rd;
   logic        unused_bits;

   assign reg_sel   = PADDR[4:2];
   assign wr_acc    = PSEL & PENABLE & PWRITE;
   assign rd_acc    = PSEL & PENABLE & ~PWRITE;
   assign ctrl_wr   = wr_acc && (reg_sel == 3'd0);
   assign div_wr    = wr_acc && (reg_sel == 3'd1);
   assign status_wr = wr_acc && (reg_sel == 3'd2);
   assign clr       = ctrl_wr & PWDATA[1];

   assign empty  = (count_reg == 9'd0);
   assign full   = (count_reg == DEPTH);
   assign strobe = en_reg && (cnt_reg == '0);
   assign pop    = rd_acc && (reg_sel == 3'd3) && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   // the sample. CLR discards a coincident sample without flagging overflow.
   assign push    = strobe && !clr && (!full || pop);
   assign ovr_set = strobe && !clr && full && !pop;

   assign PREADY      = 1'b1;
   assign PSLVERR     = 1'b0;
   assign IRQ         = irq_reg;
   assign unused_bits = ^{PADDR[11:5], PADDR[1:0], PWDATA};

`ifdef ADC_CMP_EN
   logic [DATA_WIDTH-1:0] cmp_reg;
   logic                  cmphit_reg;
   logic                  cmp_wr;

   assign cmp_wr = wr_acc && (reg_sel == 3'd4);
   assign cmphit = cmphit_reg;
   assign cmp_rd = 32'(cmp_reg);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cmp_reg    <= '0;
         cmphit_reg <= 1'b0;
      end else begin
         if (cmp_wr)
            cmp_reg <= PWDATA[DATA_WIDTH-1:0];
         // A new hit wins over a clear in the same cycle.
         if (push && (ADC_DATA > cmp_reg))
            cmphit_reg <= 1'b1;
         else if (status_wr && PWDATA[19])
            cmphit_reg <= 1'b0;
      end
   end
`else
   assign cmphit = 1'b0;
   assign cmp_rd = '0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         en_reg     <= 1'b0;
         ie_reg     <= 1'b0;
         wm_reg     <= '0;
         div_reg    <= '0;
         cnt_reg    <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovr_reg    <= 1'b0;
         irq_reg    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            en_reg <= PWDATA[0];
            ie_reg <= PWDATA[2];
            wm_reg <= PWDATA[15:8];
         end
         if (div_wr)
            div_reg <= PWDATA[DIV_WIDTH-1:0];

         // Reload while idle and on every strobe, so a new DIV lands only at
         // a period boundary.
         if (!en_reg || (cnt_reg == '0))
            cnt_reg <= div_reg;
         else
            cnt_reg <= cnt_reg - 1'b1;

         if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + 9'(push) - 9'(pop);
         end

         if (ovr_set)
            ovr_reg <= 1'b1;
         else if (status_wr && PWDATA[18])
            ovr_reg <= 1'b0;

         irq_reg <= ie_reg & (((count_reg >= {1'b0, wm_reg}) && (wm_reg != 8'd0))
                              | ovr_reg | cmphit);
      end
   end

   // Sample storage carries no reset; only the pointers define validity.
   always_ff @(posedge PCLK) begin
      if (push)
         mem[wr_ptr_reg] <= ADC_DATA;
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (reg_sel)
            3'd0: PRDATA = {16'b0, wm_reg, 5'b0, ie_reg, 1'b0, en_reg};
            3'd1: PRDATA = 32'(div_reg);
            3'd2: PRDATA = {12'b0, cmphit, ovr_reg, full, empty, 7'b0, count_reg};
            3'd3: if (!empty) PRDATA = 32'(mem[rd_ptr_reg]);
            3'd4: PRDATA = cmp_rd;
            default: PRDATA = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_adc_sampler.sv
module tb_apb_adc_sampler;
   localparam int DW    = 12;
   localparam int DEPTH = 16;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [11:0]   PADDR = '0;
   logic [31:0]   PWDATA = '0;
   logic [31:0]   PRDATA;
   logic          PREADY, PSLVERR, IRQ;
   logic [DW-1:0] ADC_DATA = '0;
   bit            adc_rand = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 PCLK = ~PCLK;

   apb_adc_sampler #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .ADC_DATA(ADC_DATA), .IRQ(IRQ)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // ---------------- behavioural reference model ----------------
   // FIFO is a queue; the sample instants are every (DIV+1)-th enabled cycle,
   // counted from the cycle after EN was written 1.
   logic [DW-1:0] m_q[$];
   bit            m_en = 0, m_ie = 0, m_ovr = 0, m_cmphit = 0, m_irq = 0;
   logic [7:0]    m_wm = '0;
   logic [15:0]   m_div = '0;
`ifdef ADC_CMP_EN
   logic [DW-1:0] m_cmp = '0;
`endif
   int            m_t = 0;

   task automatic model_reset();
      m_q.delete();
      m_en = 0; m_ie = 0; m_ovr = 0; m_cmphit = 0; m_irq = 0;
      m_wm = '0; m_div = '0; m_t = 0;
`ifdef ADC_CMP_EN
      m_cmp = '0;
`endif
   endtask

   task automatic model_step();
      bit wr, rd, smp, irq_n;
      int a;
      wr    = PSEL && PENABLE && PWRITE;
      rd    = PSEL && PENABLE && !PWRITE;
      a     = int'(PADDR[4:2]);
      smp   = m_en && ((m_t % (int'(m_div) + 1)) == int'(m_div));
      irq_n = m_ie && (((m_q.size() >= int'(m_wm)) && (m_wm != 0)) || m_ovr || m_cmphit);
      if (m_en) m_t++; else m_t = 0;
      if (wr && a == 2) begin
         if (PWDATA[18]) m_ovr = 0;
`ifdef ADC_CMP_EN
         if (PWDATA[19]) m_cmphit = 0;
`endif
      end
      if (wr && a == 0 && PWDATA[1]) begin
         m_q.delete();
      end else begin
         if (rd && a == 3 && m_q.size() > 0) void'(m_q.pop_front());
         if (smp) begin
            if (m_q.size() < DEPTH) begin
               m_q.push_back(ADC_DATA);
`ifdef ADC_CMP_EN
               if (ADC_DATA > m_cmp) m_cmphit = 1;
`endif
            end else begin
               m_ovr = 1;
            end
         end
      end
      m_irq = irq_n;
      if (wr && a == 0) begin m_en = PWDATA[0]; m_ie = PWDATA[2]; m_wm = PWDATA[15:8]; end
      if (wr && a == 1) m_div = PWDATA[15:0];
`ifdef ADC_CMP_EN
      if (wr && a == 4) m_cmp = PWDATA[DW-1:0];
`endif
   endtask

   function automatic logic [31:0] model_read(input int idx);
      logic [31:0] r;
      r = '0;
      case (idx)
         0: r = {16'h0, m_wm, 5'b0, m_ie, 1'b0, m_en};
         1: r = {16'h0, m_div};
         2: r = {12'h0, m_cmphit, m_ovr, (m_q.size() == DEPTH), (m_q.size() == 0), 7'b0, 9'(m_q.size())};
         3: if (m_q.size() > 0) r = 32'(m_q[0]);
`ifdef ADC_CMP_EN
         4: r = 32'(m_cmp);
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge PCLK or negedge PRESETn);
         if (!PRESETn) model_reset();
         else model_step();
      end
   end

   // ---------------- scoreboard + monitor ----------------
   typedef struct { string name; logic [31:0] exp; } exp_t;
   exp_t sb_q[$];

   initial begin
      exp_t e;
      forever begin
         @(negedge PCLK);
         if (PRESETn) begin
            check("irq_cycle", 32'(IRQ), 32'(m_irq));
            if (PSEL && PENABLE && !PWRITE) begin
               if (sb_q.size() == 0) begin
                  check("sb_unexpected_read", 32'(sb_q.size()), 32'd1);
               end else begin
                  e = sb_q.pop_front();
                  check(e.name, PRDATA, e.exp);
                  check("pready", 32'(PREADY), 32'd1);
                  check("pslverr", 32'(PSLVERR), 32'd0);
               end
            end
         end
      end
   end

   always begin
      @(posedge PCLK);
      #1;
      if (adc_rand) ADC_DATA = 12'($urandom);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   task automatic apb_write(input int idx, input logic [31:0] data);
      PSEL = 1; PENABLE = 0; PWRITE = 1; PWDATA = data;
      PADDR = {7'($urandom), 3'(idx), 2'($urandom)};
      tick(1);
      PENABLE = 1;
      tick(1);
      PSEL = 0; PENABLE = 0; PWRITE = 0;
      $display("write addr=0x%02h data=0x%08h", idx * 4, data);
   endtask

   task automatic apb_read(input int idx, input string name, input bit use_const,
                           input logic [31:0] cexp);
      logic [31:0] e;
      PSEL = 1; PENABLE = 0; PWRITE = 0;
      PADDR = {7'($urandom), 3'(idx), 2'($urandom)};
      tick(1);
      PENABLE = 1;
      e = use_const ? cexp : model_read(idx);
      sb_q.push_back('{name, e});
      $display("read  addr=0x%02h %s expect=0x%08h", idx * 4, name, e);
      tick(1);
      PSEL = 0; PENABLE = 0;
   endtask

   initial begin
      int k, kind, idx;
      logic [31:0] d;
      logic [31:0] irq_cmp_exp, st_cmp_exp, cmp_exp;
`ifdef ADC_CMP_EN
      irq_cmp_exp = 32'd1; st_cmp_exp = 32'h0008_0002; cmp_exp = 32'h800;
`else
      irq_cmp_exp = 32'd0; st_cmp_exp = 32'h0000_0002; cmp_exp = 32'h0;
`endif
      tick(3);
      PRESETn = 1;
      tick(1);

      // reset state
      check("irq_reset", 32'(IRQ), 32'd0);
      apb_read(0, "ctrl_reset", 1, 32'h0);
      apb_read(1, "div_reset", 1, 32'h0);
      apb_read(2, "status_reset", 1, 32'h0001_0000);
      apb_read(3, "data_empty_reset", 1, 32'h0);
      apb_read(4, "cmp_reset", 1, 32'h0);
      apb_read(5, "reserved_read", 1, 32'h0);

      // DIV=3, fixed ADC code, 8 samples
      ADC_DATA = 12'hABC;
      apb_write(1, 32'd3);
      apb_write(0, 32'h1);
      k = 0;
      while (m_q.size() != 8 && k < 500) begin tick(1); k++; end
      check("wait_8_samples", 32'(k < 500), 32'd1);
      apb_write(0, 32'h0);
      apb_read(2, "status_count8", 1, 32'h0000_0008);
      apb_read(3, "data_abc", 1, 32'h0000_0ABC);

      // fill to full and overflow
      apb_write(0, 32'h2);
      adc_rand = 1;
      apb_write(1, 32'd0);
      apb_write(0, 32'h1);
      k = 0;
      while (!m_ovr && k < 500) begin tick(1); k++; end
      check("wait_ovr", 32'(k < 500), 32'd1);
      apb_write(0, 32'h0);
      apb_read(2, "status_full_ovr", 1, 32'h0006_0010);
      apb_write(2, 32'h0004_0000);
      apb_read(2, "status_ovr_cleared", 1, 32'h0002_0010);

      // full FIFO: DATA read lands on a strobe cycle
      apb_write(1, 32'd3);
      apb_write(0, 32'h1);
      k = 0;
      while (!(m_en && (m_t % 4) == 2) && k < 500) begin tick(1); k++; end
      check("wait_phase_pop", 32'(k < 500), 32'd1);
      apb_read(3, "data_oldest_on_strobe", 0, 32'h0);
      apb_write(0, 32'h0);
      apb_read(2, "status_full_no_ovr", 1, 32'h0002_0010);

      // set OVR, then CLR coinciding with a strobe
      apb_write(0, 32'h1);
      k = 0;
      while (!(m_ovr && (m_t % 4) == 2) && k < 500) begin tick(1); k++; end
      check("wait_phase_clr", 32'(k < 500), 32'd1);
      apb_write(0, 32'h2);
      apb_read(2, "status_after_clr", 1, 32'h0005_0000);
      apb_read(3, "data_after_clr", 1, 32'h0);
      apb_write(2, 32'h0004_0000);
      apb_read(2, "status_clean", 1, 32'h0001_0000);

      // watermark interrupt
      apb_write(1, 32'd0);
      apb_write(0, 32'h0805);
      k = 0;
      while (m_q.size() != 6 && k < 500) begin tick(1); k++; end
      check("wait_count6", 32'(k < 500), 32'd1);
      apb_write(0, 32'h0804);
      tick(2);
      check("irq_wm_high", 32'(IRQ), 32'd1);
      apb_read(2, "status_wm8", 1, 32'h0000_0008);
      apb_read(3, "data_drain_one", 0, 32'h0);
      tick(2);
      check("irq_wm_low", 32'(IRQ), 32'd0);
      apb_write(0, 32'h2);

      // comparator
      adc_rand = 0;
      apb_write(1, 32'd7);
      apb_write(4, 32'h800);
      ADC_DATA = 12'h7FF;
      apb_write(0, 32'h5);
      k = 0;
      while (m_q.size() != 1 && k < 500) begin tick(1); k++; end
      check("wait_cmp_push1", 32'(k < 500), 32'd1);
      apb_write(0, 32'h4);
      tick(2);
      check("irq_cmp_below", 32'(IRQ), 32'd0);
      apb_read(2, "status_cmp_below", 1, 32'h0000_0001);
      ADC_DATA = 12'h801;
      apb_write(0, 32'h5);
      k = 0;
      while (m_q.size() != 2 && k < 500) begin tick(1); k++; end
      check("wait_cmp_push2", 32'(k < 500), 32'd1);
      apb_write(0, 32'h4);
      tick(2);
      check("irq_cmp_above", 32'(IRQ), irq_cmp_exp);
      apb_read(2, "status_cmp_above", 1, st_cmp_exp);
      apb_read(4, "cmp_readback", 1, cmp_exp);
`ifdef ADC_CMP_EN
      apb_write(2, 32'h0008_0000);
      apb_read(2, "status_cmphit_cleared", 1, 32'h0000_0002);
`endif
      apb_write(0, 32'h2);

      // randomized traffic against the model
      adc_rand = 1;
      for (int i = 0; i < 150; i++) begin
         tick($urandom_range(0, 2));
         kind = $urandom_range(0, 9);
         if (kind < 5) begin
            apb_read($urandom_range(0, 7), "rand_read", 0, 32'h0);
         end else begin
            idx = $urandom_range(0, 7);
            d = $urandom;
            if (idx == 0)
               d = {16'h0, 8'($urandom_range(0, 18)), 5'b0, d[2], ($urandom_range(0, 7) == 0), d[0]};
            if (idx == 1) begin
               if (m_en) idx = 2;
               else d = {d[31:16], 16'($urandom_range(0, 3))};
            end
            apb_write(idx, d);
         end
      end
      apb_write(0, 32'h0);

      // asynchronous reset mid-operation
      apb_write(1, 32'd0);
      apb_write(0, 32'h0105);
      tick(4);
      check("irq_before_reset", 32'(IRQ), 32'd1);
      #2;
      PRESETn = 0;
      #1;
      check("irq_async_reset", 32'(IRQ), 32'd0);
      @(posedge PCLK);
      #1;
      PRESETn = 1;
      tick(1);
      apb_read(0, "ctrl_after_reset", 1, 32'h0);
      apb_read(1, "div_after_reset", 1, 32'h0);
      apb_read(2, "status_after_reset", 1, 32'h0001_0000);

      // first strobe comes DIV+1 cycles after EN
      apb_write(1, 32'd2);
      apb_write(0, 32'h1);
      apb_read(2, "status_before_first_strobe", 1, 32'h0001_0000);
      apb_read(2, "status_first_strobe", 1, 32'h0000_0001);
      apb_write(0, 32'h2);
      tick(2);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
